// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// a ready-handshake memory and a watchdog that aborts stalled accesses.
module multicycle_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       Overflow,
  input  logic       MemRdy,
  output logic       PCWr,
  output logic       IRWr,
  output logic [1:0] RegDst,
  output logic       ALUSrc,
  output logic [1:0] Mem2Reg,
  output logic       RegWr,
  output logic       MemWr,
  output logic [1:0] NPCSel,
  output logic [1:0] EXTOp,
  output logic [2:0] ALUOp,
  output logic [1:0] FlagOp,
  output logic       MemRd,
  output logic [2:0] State,
  output logic       IllegalInstr,
  output logic       BusErr
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_stall;
  logic             w_timeout;

  logic w_special, w_addu, w_subu, w_slt, w_jr;
  logic w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal, w_addi, w_addiu;
  logic w_rtype, w_alu;

  assign w_special = (opcode == 6'b000000);
  assign w_addu    = w_special && (funct == 6'b100001);
  assign w_subu    = w_special && (funct == 6'b100011);
  assign w_slt     = w_special && (funct == 6'b101010);
  assign w_jr      = w_special && (funct == 6'b001000);
  assign w_ori     = (opcode == 6'b001101);
  assign w_lw      = (opcode == 6'b100011);
  assign w_sw      = (opcode == 6'b101011);
  assign w_beq     = (opcode == 6'b000100);
  assign w_lui     = (opcode == 6'b001111);
  assign w_j       = (opcode == 6'b000010);
  assign w_jal     = (opcode == 6'b000011);
  assign w_addi    = (opcode == 6'b001000);
  assign w_addiu   = (opcode == 6'b001001);
  assign w_rtype   = w_addu || w_subu || w_slt;
  assign w_alu     = w_rtype || w_ori || w_lui || w_addi || w_addiu;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign State     = rst ? 3'd0 : r_state;

  // Strobes, selects and next state; everything is held at 0 during reset.
  always_comb begin
    PCWr = 1'b0; IRWr = 1'b0; RegDst = 2'b00; ALUSrc = 1'b0; Mem2Reg = 2'b00;
    RegWr = 1'b0; MemWr = 1'b0; NPCSel = 2'b00; EXTOp = 2'b00; ALUOp = ALU_ADD;
    FlagOp = 2'b00; MemRd = 1'b0; IllegalInstr = 1'b0; BusErr = 1'b0;
    w_next = r_state;
    w_stall = 1'b0;
    if (rst) begin
      w_next = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          MemRd = 1'b1;
          if (MemRdy) begin
            IRWr = 1'b1;
            w_next = S_DECODE;
          end else if (w_timeout) begin
            BusErr = 1'b1;
            PCWr = 1'b1;
            w_next = S_FETCH;
          end else begin
            w_stall = 1'b1;
          end
        end
        S_DECODE: begin
          if (w_alu || w_lw || w_sw || w_beq) begin
            w_next = S_EXEC;
          end else if (w_j) begin
            PCWr = 1'b1; NPCSel = 2'b10; w_next = S_FETCH;
          end else if (w_jr) begin
            PCWr = 1'b1; NPCSel = 2'b11; w_next = S_FETCH;
          end else if (w_jal) begin
            w_next = S_WB;
          end else begin
            IllegalInstr = 1'b1; PCWr = 1'b1; w_next = S_FETCH;
          end
        end
        S_EXEC: begin
          if (w_addu) begin
            ALUOp = ALU_ADD;
          end else if (w_subu || w_beq) begin
            ALUOp = ALU_SUB;
          end else if (w_slt) begin
            ALUOp = ALU_SLT;
          end else if (w_ori) begin
            ALUSrc = 1'b1; EXTOp = 2'b00; ALUOp = ALU_OR;
          end else if (w_lui) begin
            ALUSrc = 1'b1; EXTOp = 2'b10; ALUOp = ALU_OR;
          end else begin
            ALUSrc = 1'b1; EXTOp = 2'b01; ALUOp = ALU_ADD;
          end
          if (w_beq) begin
            PCWr = 1'b1;
            NPCSel = Zero ? 2'b01 : 2'b00;
            w_next = S_FETCH;
          end else if (w_lw || w_sw) begin
            w_next = S_MEM;
          end else if (w_alu) begin
            w_next = S_WB;
          end else begin
            w_next = S_FETCH;
          end
        end
        S_MEM: begin
          ALUSrc = 1'b1; EXTOp = 2'b01; ALUOp = ALU_ADD;
          // The timeout abort suppresses the write strobe so a stuck store cannot land late.
          if (w_lw) begin
            MemRd = 1'b1;
            if (MemRdy) begin
              w_next = S_WB;
            end else if (w_timeout) begin
              BusErr = 1'b1; PCWr = 1'b1; w_next = S_FETCH;
            end else begin
              w_stall = 1'b1;
            end
          end else if (w_sw) begin
            if (MemRdy) begin
              MemWr = 1'b1; PCWr = 1'b1; w_next = S_FETCH;
            end else if (w_timeout) begin
              BusErr = 1'b1; PCWr = 1'b1; w_next = S_FETCH;
            end else begin
              MemWr = 1'b1; w_stall = 1'b1;
            end
          end else begin
            w_next = S_FETCH;
          end
        end
        S_WB: begin
          RegWr = 1'b1;
          PCWr = 1'b1;
          RegDst = w_rtype ? 2'b01 : (w_jal ? 2'b10 : 2'b00);
          Mem2Reg = w_lw ? 2'b01 : (w_jal ? 2'b10 : 2'b00);
          NPCSel = w_jal ? 2'b10 : 2'b00;
          FlagOp = r_ovf ? 2'b01 : 2'b00;
          w_next = S_FETCH;
        end
        default: begin
          w_next = S_FETCH;
        end
      endcase
    end
  end

  // State, wait counter and the overflow flag carried from EXEC into WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cnt   <= {CNT_W{1'b0}};
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_stall) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= {CNT_W{1'b0}};
      end
      if (r_state == S_EXEC) begin
        r_ovf <= (w_next == S_WB) && Overflow && w_addi;
      end else if (r_state == S_WB) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle checks of state and
// strobes for each instruction class, stalls, timeout, illegal opcode, reset.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       Zero, Overflow, MemRdy;
  logic       PCWr, IRWr, ALUSrc, RegWr, MemWr, MemRd, IllegalInstr, BusErr;
  logic [1:0] RegDst, Mem2Reg, NPCSel, EXTOp, FlagOp;
  logic [2:0] ALUOp, State;
  logic [23:0] all_outs;

  int n_total = 0;
  int n_pass  = 0;
  int ncyc    = 0;
  logic regwr_seen;

  multicycle_controller #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .Zero(Zero),
    .Overflow(Overflow), .MemRdy(MemRdy), .PCWr(PCWr), .IRWr(IRWr),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .Mem2Reg(Mem2Reg), .RegWr(RegWr),
    .MemWr(MemWr), .NPCSel(NPCSel), .EXTOp(EXTOp), .ALUOp(ALUOp),
    .FlagOp(FlagOp), .MemRd(MemRd), .State(State),
    .IllegalInstr(IllegalInstr), .BusErr(BusErr)
  );

  assign all_outs = {PCWr, IRWr, RegDst, ALUSrc, Mem2Reg, RegWr, MemWr, NPCSel,
                     EXTOp, ALUOp, FlagOp, MemRd, State, IllegalInstr, BusErr};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  // FETCH with a junk opcode on the bus: must be ignored, IR loads.
  task automatic fetch(input string tag);
    ncyc = 0;
    opcode = 6'b111111; funct = 6'b000000; MemRdy = 1'b1; Zero = 1'b0; Overflow = 1'b0;
    #1;
    chk({tag, " F state"}, State, 3'd0);
    chk({tag, " F MemRd"}, MemRd, 1'b1);
    chk({tag, " F IRWr"}, IRWr, 1'b1);
    chk({tag, " F Illegal"}, IllegalInstr, 1'b0);
    step();
  endtask

  task automatic run_alu(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic src, input logic [1:0] ext, input logic [2:0] aop,
                         input logic [1:0] rdst, input logic ovf, input logic [1:0] flag);
    fetch(tag);
    opcode = op; funct = fn;
    #1;
    chk({tag, " D state"}, State, 3'd1);
    chk({tag, " D PCWr"}, PCWr, 1'b0);
    step();
    Overflow = ovf;
    #1;
    chk({tag, " E state"}, State, 3'd2);
    chk({tag, " E ALUSrc"}, ALUSrc, src);
    chk({tag, " E EXTOp"}, EXTOp, ext);
    chk({tag, " E ALUOp"}, ALUOp, aop);
    chk({tag, " E PCWr"}, PCWr, 1'b0);
    step();
    Overflow = 1'b0;
    #1;
    chk({tag, " W state"}, State, 3'd4);
    chk({tag, " W RegWr"}, RegWr, 1'b1);
    chk({tag, " W PCWr"}, PCWr, 1'b1);
    chk({tag, " W RegDst"}, RegDst, rdst);
    chk({tag, " W Mem2Reg"}, Mem2Reg, 2'b00);
    chk({tag, " W FlagOp"}, FlagOp, flag);
    step();
    chk({tag, " back to F"}, State, 3'd0);
    chk({tag, " latency"}, ncyc, 4);
  endtask

  task automatic beq_run(input string tag, input logic z, input logic [1:0] nsel);
    fetch(tag);
    opcode = 6'b000100;
    #1;
    chk({tag, " D state"}, State, 3'd1);
    step();
    Zero = z;
    #1;
    chk({tag, " E ALUOp"}, ALUOp, 3'b001);
    chk({tag, " E PCWr"}, PCWr, 1'b1);
    chk({tag, " E NPCSel"}, NPCSel, nsel);
    chk({tag, " E RegWr"}, RegWr, 1'b0);
    step();
    Zero = 1'b0;
    chk({tag, " back to F"}, State, 3'd0);
    chk({tag, " latency"}, ncyc, 3);
  endtask

  // Store that stalls for 'stalls' cycles, then optionally gets ready.
  task automatic sw_run(input string tag, input int stalls, input logic rdy_last);
    fetch(tag);
    opcode = 6'b101011;
    step();
    #1;
    chk({tag, " E EXTOp"}, EXTOp, 2'b01);
    step();
    MemRdy = 1'b0;
    regwr_seen = 1'b0;
    for (int i = 0; i < stalls; i++) begin
      #1;
      chk({tag, " M state"}, State, 3'd3);
      chk({tag, " M MemWr held"}, MemWr, 1'b1);
      chk({tag, " M no BusErr"}, BusErr, 1'b0);
      chk({tag, " M no PCWr"}, PCWr, 1'b0);
      regwr_seen = regwr_seen | RegWr;
      step();
    end
    MemRdy = rdy_last;
    #1;
    chk({tag, " last state"}, State, 3'd3);
    chk({tag, " last BusErr"}, BusErr, !rdy_last);
    chk({tag, " last MemWr"}, MemWr, rdy_last);
    chk({tag, " last PCWr"}, PCWr, 1'b1);
    chk({tag, " last NPCSel"}, NPCSel, 2'b00);
    regwr_seen = regwr_seen | RegWr;
    step();
    MemRdy = 1'b1;
    #1;
    chk({tag, " back to F"}, State, 3'd0);
    chk({tag, " BusErr one pulse"}, BusErr, 1'b0);
    chk({tag, " RegWr never"}, regwr_seen, 1'b0);
  endtask

  initial begin
    rst = 1'b1; opcode = 6'b000000; funct = 6'b000000;
    Zero = 1'b0; Overflow = 1'b0; MemRdy = 1'b1;
    #3;
    chk("reset all outputs 0", all_outs, 24'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post-reset state", State, 3'd0);

    run_alu("addu",  6'b000000, 6'b100001, 1'b0, 2'b00, 3'b000, 2'b01, 1'b0, 2'b00);
    run_alu("subu",  6'b000000, 6'b100011, 1'b0, 2'b00, 3'b001, 2'b01, 1'b0, 2'b00);
    run_alu("slt",   6'b000000, 6'b101010, 1'b0, 2'b00, 3'b011, 2'b01, 1'b0, 2'b00);
    run_alu("ori",   6'b001101, 6'b000000, 1'b1, 2'b00, 3'b010, 2'b00, 1'b0, 2'b00);
    run_alu("lui",   6'b001111, 6'b000000, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0, 2'b00);
    run_alu("addi ovf",  6'b001000, 6'b000000, 1'b1, 2'b01, 3'b000, 2'b00, 1'b1, 2'b01);
    run_alu("addiu ovf", 6'b001001, 6'b000000, 1'b1, 2'b01, 3'b000, 2'b00, 1'b1, 2'b00);

    beq_run("beq taken", 1'b1, 2'b01);
    beq_run("beq not taken", 1'b0, 2'b00);

    // lw with three stalled MEM cycles
    fetch("lw");
    opcode = 6'b100011;
    step();
    step();
    MemRdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) MemRdy = 1'b1;
      #1;
      chk("lw M state", State, 3'd3);
      chk("lw M MemRd", MemRd, 1'b1);
      chk("lw M RegWr", RegWr, 1'b0);
      step();
    end
    #1;
    chk("lw W state", State, 3'd4);
    chk("lw W Mem2Reg", Mem2Reg, 2'b01);
    chk("lw W RegWr", RegWr, 1'b1);
    chk("lw W RegDst", RegDst, 2'b00);
    step();
    chk("lw latency", ncyc, 8);

    sw_run("sw timeout", 15, 1'b0);
    sw_run("sw ready at limit", 15, 1'b1);
    sw_run("sw fast", 0, 1'b1);

    fetch("j");
    opcode = 6'b000010;
    #1;
    chk("j D PCWr", PCWr, 1'b1);
    chk("j D NPCSel", NPCSel, 2'b10);
    step();
    chk("j latency", ncyc, 2);
    chk("j back to F", State, 3'd0);

    fetch("jr");
    opcode = 6'b000000; funct = 6'b001000;
    #1;
    chk("jr D PCWr", PCWr, 1'b1);
    chk("jr D NPCSel", NPCSel, 2'b11);
    step();
    chk("jr back to F", State, 3'd0);

    fetch("jal");
    opcode = 6'b000011;
    #1;
    chk("jal D PCWr", PCWr, 1'b0);
    step();
    #1;
    chk("jal W state", State, 3'd4);
    chk("jal W RegDst", RegDst, 2'b10);
    chk("jal W Mem2Reg", Mem2Reg, 2'b10);
    chk("jal W NPCSel", NPCSel, 2'b10);
    chk("jal W RegWr", RegWr, 1'b1);
    step();
    chk("jal latency", ncyc, 3);

    fetch("illegal");
    opcode = 6'b111111;
    #1;
    chk("illegal D pulse", IllegalInstr, 1'b1);
    chk("illegal D PCWr", PCWr, 1'b1);
    chk("illegal D NPCSel", NPCSel, 2'b00);
    step();
    chk("illegal one cycle", IllegalInstr, 1'b0);
    chk("illegal back to F", State, 3'd0);

    // reset asserted in the middle of a stalled load
    fetch("rst mid-MEM");
    opcode = 6'b100011;
    step();
    step();
    MemRdy = 1'b0;
    #1;
    chk("pre-reset MEM state", State, 3'd3);
    step();
    MemRdy = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid-MEM reset outputs 0", all_outs, 24'd0);
    step();
    rst = 1'b0;
    opcode = 6'b000000;
    #1;
    chk("after reset state", State, 3'd0);
    chk("after reset IRWr", IRWr, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the MIPS datapath: PC, IR, register file, EXT, ALU, data RAM, NPC and flag register.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK over several cycles.
- Issues the same datapath select signals as the single-cycle decode, plus PC/IR write strobes.
- Tolerates a shared memory with a ready handshake, guarded by a timeout watchdog.

Parameters:
- TIMEOUT, 16: maximum wait cycles for MemRdy in FETCH or MEM before a bus-error abort.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0].
- Zero  in  1  ALU zero; combinational, current cycle.
- Overflow  in  1  ALU signed overflow; combinational, current cycle.
- MemRdy  in  1  memory access complete this cycle.
- PCWr  out  1  PC load strobe.
- IRWr  out  1  IR load strobe.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- ALUSrc  out  1  0 = register B, 1 = EXT.
- Mem2Reg  out  2  00 ALU, 01 RAM, 10 PC+4.
- RegWr  out  1  register-file write enable.
- MemWr  out  1  RAM write enable.
- NPCSel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 register jump.
- EXTOp  out  2  00 zero-extend, 01 sign-extend, 10 LUI.
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 set-less-than.
- FlagOp  out  2  00 disabled, 01 set-and-write overflow flag.
- MemRd  out  1  memory read request.
- State  out  3  current state, for debug.
- IllegalInstr  out  1  one-cycle pulse on an undecodable instruction.
- BusErr  out  1  one-cycle pulse on a memory timeout.

Behaviour:
- Decoded instruction set:
  - SPECIAL (000000) with funct addu 100001, subu 100011, slt 101010, jr 001000.
  - ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011, addi 001000, addiu 001001.
- State encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4. Codes 5-7 return to FETCH next cycle with all outputs 0.
- Reset:
  - Async on rst: State=FETCH, wait counter=0, ovf_q=0.
  - All outputs forced to 0 while rst is high, including MemRdy-dependent strobes.
- Output default: every output not listed for the current state/instruction is 0.
- Output timing: outputs are combinational from State, opcode/funct, Zero, and MemRdy; the only registered flag is ovf_q.
- FETCH:
  - MemRd=1.
  - MemRdy=1: IRWr=1, go to DECODE.
  - Otherwise hold and increment the counter.
- DECODE:
  - ALU-class, lw, sw, beq: go to EXEC.
  - j: PCWr=1, NPCSel=10, go to FETCH.
  - jr: PCWr=1, NPCSel=11, go to FETCH.
  - jal: go to WB.
  - Unknown instruction: IllegalInstr=1, PCWr=1, NPCSel=00, go to FETCH.
- EXEC: ALU controls match the single-cycle decode:
  - addu: ALUSrc=0, ALUOp=add.
  - subu: ALUSrc=0, ALUOp=sub.
  - slt: ALUSrc=0, ALUOp=less.
  - ori: ALUSrc=1, EXTOp=zero, ALUOp=or.
  - lui: ALUSrc=1, EXTOp=lui, ALUOp=or.
  - addi / addiu: ALUSrc=1, EXTOp=sign, ALUOp=add.
  - lw / sw: ALUSrc=1, EXTOp=sign, ALUOp=add.
  - beq: ALUOp=sub, PCWr=1, NPCSel = 01 if Zero else 00, go to FETCH.
  - Other ALU-class: go to WB; ovf_q <= Overflow & addi.
  - lw, sw: go to MEM.
- MEM:
  - ALU controls held as in EXEC.
  - lw: MemRd=1; on MemRdy go to WB.
  - sw: MemWr=1 held until MemRdy; on MemRdy PCWr=1, NPCSel=00, go to FETCH.
- WB:
  - RegWr=1 and PCWr=1; go to FETCH.
  - RegDst: rd for addu/subu/slt, $31 for jal, rt otherwise.
  - Mem2Reg: RAM for lw, PC+4 for jal, ALU otherwise.
  - NPCSel: 10 for jal, otherwise 00.
  - FlagOp=01 iff ovf_q; ovf_q clears on exit.
- Wait counter:
  - Cleared on every state change; increments each stalled cycle in FETCH or MEM.
  - When counter == TIMEOUT-1 and MemRdy=0: BusErr=1, MemWr=0, PCWr=1, NPCSel=00, go to FETCH; no register write.
  - MemRdy=1 on the timeout cycle: completes normally, no BusErr.
- Latency with MemRdy tied to 1:
  - 4 cycles: R-type, ori, lui, addi, addiu, sw.
  - 5 cycles: lw.
  - 3 cycles: beq, jal.
  - 2 cycles: j, jr.
- Opcode/funct are ignored in FETCH. Zero/Overflow are used only in EXEC.

Test Plan:
- addu, MemRdy=1: States 0,1,2,4; RegWr=1, RegDst=01, PCWr=1 only in WB; next State=0.
- beq: Zero=1 gives PCWr=1, NPCSel=01 in EXEC; Zero=0 gives NPCSel=00; 3 cycles each.
- lw with MemRdy low for 3 MEM cycles: MemRd held 4 cycles; WB gives Mem2Reg=01, RegWr=1; total 8 cycles.
- sw with MemRdy never asserted, TIMEOUT=16: after 16 MEM cycles BusErr pulses once, MemWr drops, PCWr=1, RegWr never set.
- addi with Overflow=1 in EXEC: WB gives FlagOp=01, RegWr=1; a following addiu gives FlagOp=00.
- opcode 111111: IllegalInstr for 1 cycle in DECODE, PCWr=1, NPCSel=00; rst asserted mid-MEM gives State=0 and all outputs 0 immediately.
